inv32_bist: RTL and testbench
=============================

Name: inv32_bist

Overview:
Built-in self-test engine for the 32-bit inverter datapath. It generates the stimulus pattern sequence, drives it into an inv32 instance, samples the response, and checks it against the expected bitwise complement. It reports busy/done/pass and a saturating error count, so silicon and gate-level runs can self-check with no testbench-side comparison.

Parameters:
WIDTH, 32, pattern/response width
NUM_RAND, 16, number of LFSR patterns after the directed set (0 allowed)
LFSR_SEED, 32'h1, LFSR start value; a value of 0 is forced to 1
ERR_W, 8, width of err_cnt

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle run request
resp_i  in  WIDTH  DUT output y (combinational from pat_o)
pat_o  out  WIDTH  pattern driven to DUT input a
busy  out  1  run in progress
done  out  1  run complete; held until the next accepted start
pass  out  1  done && err_cnt==0
err_cnt  out  ERR_W  mismatching patterns, saturating at all-ones
pat_idx  out  8  index of the pattern currently on pat_o

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-high.
- Reset values: pat_o=0, busy=0, done=0, pass=0, err_cnt=0, pat_idx=0, FSM=IDLE, LFSR=seed.
- FSM states: IDLE, DIR, RAND, DONE.
- IDLE/DONE + start=1: next cycle enter DIR, pat_idx=0, err_cnt=0, done=0, LFSR reloaded.
- DIR: applies patterns in this fixed order, one per cycle:
  - 0: 32'h00000000
  - 1: 32'hFFFFFFFF
  - 2: 32'hAAAAAAAA
  - 3: 32'h0000FFFF
  - 4: 32'hCCCCCCCC
- After pattern 4: go to RAND if NUM_RAND>0, otherwise go to DONE.
- RAND: pat_o = LFSR state. Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003), advances once per applied pattern. Produces NUM_RAND patterns, then enters DONE.
- Check timing: a pattern is registered onto pat_o and held exactly one cycle. resp_i is compared with ~pat_o on the rising edge that ends that cycle. A mismatch increments err_cnt (saturating, no wrap). Total run is 5+NUM_RAND cycles with busy=1.
- Final check: the DONE entry edge also samples the last pattern's response. done and pass become valid the cycle after the last pattern is applied.
- pat_o returns to 0 in IDLE/DONE.
- start while busy: ignored; the run continues unaffected.
- start in DONE: restarts the run; the counters clear.
- rst asserted mid-run: all outputs go to their reset values immediately (asynchronous); no partial result is retained.
- Widths: WIDTH other than 32 is supported only if directed patterns are truncated/replicated to WIDTH; the LFSR stays 32-bit and its low WIDTH bits are used.

Optional Feature:
INV32_BIST_FAILLOG_EN
- Defined: adds outputs fail_valid (1), fail_idx (8), fail_pat (WIDTH), fail_resp (WIDTH). These capture the first mismatching pattern of a run. They clear on start/reset and are not overwritten by later failures.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package inv32_pkg holds:
  - WIDTH default
  - the five directed pattern constants
  - the LFSR polynomial mask
  - the FSM state enum (IDLE/DIR/RAND/DONE)
- One natural sub-module: lfsr32 (load, advance enable, Galois step, zero-seed guard). The FSM, comparator and counter stay in inv32_bist.

Test Plan:
1. Golden inv32 attached, NUM_RAND=16, start pulse -> busy high 21 cycles; pat_o sequence 0, FFFFFFFF, AAAAAAAA, 0000FFFF, CCCCCCCC, then LFSR from seed 1; done=1, pass=1, err_cnt=0.
2. DUT model with y[0] stuck-at-0, NUM_RAND=0 -> fails on patterns 0, 2, 4; err_cnt=3, pass=0. With INV32_BIST_FAILLOG_EN: fail_idx=0, fail_pat=0, fail_resp=FFFFFFFE.
3. start re-pulsed at cycle 3 of a run -> ignored; run length stays 5+NUM_RAND cycles and pat_idx sequence is unbroken.
4. rst asserted at pat_idx=7 -> same cycle pat_o=0, busy=0, err_cnt=0; a new start afterwards reproduces test 1 exactly.
5. DUT forced to output all zeros, ERR_W=2, NUM_RAND=16 -> err_cnt saturates at 3 (no wrap), pass=0.
6. LFSR_SEED=0 -> first random pattern equals the LFSR step from seed 1, not 0; pass=1 with golden DUT.

Source files
------------

// File: rtl/inv32_pkg.sv
// inv32_pkg: shared constants, FSM state type and LFSR helpers for the
// inv32 built-in self-test engine (inv32_bist and lfsr32).
package inv32_pkg;

  localparam int          WIDTH_DEF = 32;
  localparam int          NUM_DIR   = 5;

  localparam logic [31:0] DIR_PAT0  = 32'h0000_0000;
  localparam logic [31:0] DIR_PAT1  = 32'hFFFF_FFFF;
  localparam logic [31:0] DIR_PAT2  = 32'hAAAA_AAAA;
  localparam logic [31:0] DIR_PAT3  = 32'h0000_FFFF;
  localparam logic [31:0] DIR_PAT4  = 32'hCCCC_CCCC;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIR  = 2'd1,
    ST_RAND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Directed pattern lookup by position in the directed set
  function automatic logic [31:0] dir_pat(input logic [2:0] idx);
    logic [31:0] p;
    case (idx)
      3'd0:    p = DIR_PAT0;
      3'd1:    p = DIR_PAT1;
      3'd2:    p = DIR_PAT2;
      3'd3:    p = DIR_PAT3;
      3'd4:    p = DIR_PAT4;
      default: p = 32'h0000_0000;
    endcase
    return p;
  endfunction

  // One Galois step: shift right, fold the taps back in when a one drops out
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    if (s[0]) begin
      n = (s >> 1) ^ LFSR_MASK;
    end else begin
      n = s >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/inv32_bist_lfsr32.sv
// lfsr32: 32-bit Galois LFSR with synchronous load, advance enable and a
// zero-seed guard (an all-zero seed would lock the register at zero).
module lfsr32
  import inv32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_adv,
  input  logic [31:0] i_seed,
  output logic [31:0] o_next
);

  logic [31:0] r_state;
  logic [31:0] w_seed_safe;

  assign w_seed_safe = (i_seed == 32'd0) ? 32'd1 : i_seed;
  assign o_next      = lfsr_step(r_state);

  // State register: load has priority over advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= w_seed_safe;
    end else if (i_load) begin
      r_state <= w_seed_safe;
    end else if (i_adv) begin
      r_state <= o_next;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: rtl/inv32_bist.sv
// inv32_bist: BIST engine for the 32-bit inverter. Drives directed then LFSR
// patterns on pat_o, checks resp_i against ~pat_o at the end of each pattern
// cycle and reports busy/done/pass and a saturating error count.
// Optional first-failure log: define INV32_BIST_FAILLOG_EN.
module inv32_bist
  import inv32_pkg::*;
#(
  parameter int          WIDTH     = WIDTH_DEF,
  parameter int          NUM_RAND  = 16,
  parameter logic [31:0] LFSR_SEED = 32'h1,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] resp_i,
  output logic [WIDTH-1:0] pat_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
`ifdef INV32_BIST_FAILLOG_EN
  output logic             fail_valid,
  output logic [7:0]       fail_idx,
  output logic [WIDTH-1:0] fail_pat,
  output logic [WIDTH-1:0] fail_resp,
`endif
  output logic [7:0]       pat_idx
);

  localparam logic [7:0]       LAST_IDX = 8'(NUM_DIR + NUM_RAND - 1);
  localparam logic [7:0]       DIR_LAST = 8'(NUM_DIR - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};

  // Map a 32-bit pattern onto WIDTH bits (truncate or replicate)
  function automatic logic [WIDTH-1:0] fit(input logic [31:0] p);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = p[i % 32];
    end
    return r;
  endfunction

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pat,   w_pat_nxt;
  logic [7:0]       r_idx,   w_idx_nxt;
  logic             r_busy,  w_busy_nxt;
  logic             r_done,  w_done_nxt;
  logic             r_pass,  w_pass_nxt;
  logic [ERR_W-1:0] r_err,   w_err_nxt;
  logic [ERR_W-1:0] w_err_chk;
  logic             w_miss;
  logic             w_accept;
  logic             w_load;
  logic             w_adv;
  logic [31:0]      w_lfsr_next;

  lfsr32 u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_adv  (w_adv),
    .i_seed (LFSR_SEED),
    .o_next (w_lfsr_next)
  );

  // Response of the pattern currently held on pat_o, judged at its closing edge
  assign w_miss    = r_busy && (resp_i != ~r_pat);
  assign w_err_chk = (w_miss && (r_err != ERR_MAX)) ? (r_err + {{(ERR_W-1){1'b0}}, 1'b1}) : r_err;
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Next-state, next-pattern and status computation
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_pass_nxt  = r_pass;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_DIR;
          w_pat_nxt   = fit(DIR_PAT0);
          w_idx_nxt   = 8'd0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_pass_nxt  = 1'b0;
          w_err_nxt   = ERR_ZERO;
          w_load      = 1'b1;
        end else begin
          w_pat_nxt   = {WIDTH{1'b0}};
          w_idx_nxt   = 8'd0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_DIR, ST_RAND: begin
        w_err_nxt = w_err_chk;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = ST_DONE;
          w_pat_nxt   = {WIDTH{1'b0}};
          w_idx_nxt   = 8'd0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_err_chk == ERR_ZERO);
        end else if ((r_state == ST_RAND) || (r_idx == DIR_LAST)) begin
          // LFSR steps before first use, so the seed itself is never applied
          w_state_nxt = ST_RAND;
          w_pat_nxt   = fit(w_lfsr_next);
          w_idx_nxt   = r_idx + 8'd1;
          w_adv       = 1'b1;
        end else begin
          w_pat_nxt   = fit(dir_pat(r_idx[2:0] + 3'd1));
          w_idx_nxt   = r_idx + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pat_nxt   = {WIDTH{1'b0}};
        w_idx_nxt   = 8'd0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = 1'b0;
        w_err_nxt   = ERR_ZERO;
      end
    endcase
  end

  // Registered FSM state and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pat   <= {WIDTH{1'b0}};
      r_idx   <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= ERR_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign pat_o   = r_pat;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign err_cnt = r_err;
  assign pat_idx = r_idx;

`ifdef INV32_BIST_FAILLOG_EN
  logic             r_fail_valid;
  logic [7:0]       r_fail_idx;
  logic [WIDTH-1:0] r_fail_pat;
  logic [WIDTH-1:0] r_fail_resp;

  // Capture only the first mismatch of a run; cleared by an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 8'd0;
      r_fail_pat   <= {WIDTH{1'b0}};
      r_fail_resp  <= {WIDTH{1'b0}};
    end else if (w_accept) begin
      r_fail_valid <= 1'b0;
      r_fail_idx   <= 8'd0;
      r_fail_pat   <= {WIDTH{1'b0}};
      r_fail_resp  <= {WIDTH{1'b0}};
    end else if (w_miss && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_idx   <= r_idx;
      r_fail_pat   <= r_pat;
      r_fail_resp  <= resp_i;
    end else begin
      r_fail_valid <= r_fail_valid;
      r_fail_idx   <= r_fail_idx;
      r_fail_pat   <= r_fail_pat;
      r_fail_resp  <= r_fail_resp;
    end
  end

  assign fail_valid = r_fail_valid;
  assign fail_idx   = r_fail_idx;
  assign fail_pat   = r_fail_pat;
  assign fail_resp  = r_fail_resp;
`else
  logic w_accept_unused;
  assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_inv32_bist.sv
// tb_inv32_bist: directed self-checking bench for inv32_bist. Four instances:
// golden inverter (NUM_RAND=16), y[0] stuck-at-0 (NUM_RAND=0), all-zero
// responder with ERR_W=2, and a zero LFSR seed. Honors INV32_BIST_FAILLOG_EN.
module tb_inv32_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // golden
  logic start_g = 1'b0;
  logic [31:0] pat_g, resp_g;
  logic busy_g, done_g, pass_g;
  logic [7:0] err_g, idx_g;
  // stuck-at
  logic start_s = 1'b0;
  logic [31:0] pat_s, resp_s;
  logic busy_s, done_s, pass_s;
  logic [7:0] err_s, idx_s;
  // saturation
  logic start_t = 1'b0;
  logic [31:0] pat_t, resp_t;
  logic busy_t, done_t, pass_t;
  logic [1:0] err_t;
  logic [7:0] idx_t;
  // zero seed
  logic start_z = 1'b0;
  logic [31:0] pat_z, resp_z;
  logic busy_z, done_z, pass_z;
  logic [7:0] err_z, idx_z;

  assign resp_g = ~pat_g;
  assign resp_s = ~pat_s & 32'hFFFF_FFFE;
  assign resp_t = 32'h0000_0000;
  assign resp_z = ~pat_z;

`ifdef INV32_BIST_FAILLOG_EN
  logic fv_g, fv_s, fv_t, fv_z;
  logic [7:0] fi_g, fi_s, fi_t, fi_z;
  logic [31:0] fp_g, fp_s, fp_t, fp_z, fr_g, fr_s, fr_t, fr_z;
`endif

  inv32_bist #(.NUM_RAND(16), .LFSR_SEED(32'h1), .ERR_W(8)) u_gold (
    .clk(clk), .rst(rst), .start(start_g), .resp_i(resp_g), .pat_o(pat_g),
    .busy(busy_g), .done(done_g), .pass(pass_g), .err_cnt(err_g),
`ifdef INV32_BIST_FAILLOG_EN
    .fail_valid(fv_g), .fail_idx(fi_g), .fail_pat(fp_g), .fail_resp(fr_g),
`endif
    .pat_idx(idx_g));

  inv32_bist #(.NUM_RAND(0), .LFSR_SEED(32'h1), .ERR_W(8)) u_stuck (
    .clk(clk), .rst(rst), .start(start_s), .resp_i(resp_s), .pat_o(pat_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .err_cnt(err_s),
`ifdef INV32_BIST_FAILLOG_EN
    .fail_valid(fv_s), .fail_idx(fi_s), .fail_pat(fp_s), .fail_resp(fr_s),
`endif
    .pat_idx(idx_s));

  inv32_bist #(.NUM_RAND(16), .LFSR_SEED(32'h1), .ERR_W(2)) u_sat (
    .clk(clk), .rst(rst), .start(start_t), .resp_i(resp_t), .pat_o(pat_t),
    .busy(busy_t), .done(done_t), .pass(pass_t), .err_cnt(err_t),
`ifdef INV32_BIST_FAILLOG_EN
    .fail_valid(fv_t), .fail_idx(fi_t), .fail_pat(fp_t), .fail_resp(fr_t),
`endif
    .pat_idx(idx_t));

  inv32_bist #(.NUM_RAND(16), .LFSR_SEED(32'h0), .ERR_W(8)) u_seed0 (
    .clk(clk), .rst(rst), .start(start_z), .resp_i(resp_z), .pat_o(pat_z),
    .busy(busy_z), .done(done_z), .pass(pass_z), .err_cnt(err_z),
`ifdef INV32_BIST_FAILLOG_EN
    .fail_valid(fv_z), .fail_idx(fi_z), .fail_pat(fp_z), .fail_resp(fr_z),
`endif
    .pat_idx(idx_z));

  logic [31:0] exp_pat [0:20];

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One golden run; optional start re-pulse at cycle 3 and optional abort by rst
  task automatic run_gold(input bit repulse, input int abort_at);
    start_g = 1'b1;
    tick();
    start_g = 1'b0;
    for (int k = 0; k < 21; k++) begin
      chk($sformatf("g_busy[%0d]", k), {31'd0, busy_g}, 32'd1);
      chk($sformatf("g_idx[%0d]", k), {24'd0, idx_g}, k);
      chk($sformatf("g_pat[%0d]", k), pat_g, exp_pat[k]);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("abort_pat", pat_g, 32'h0);
        chk("abort_busy", {31'd0, busy_g}, 32'd0);
        chk("abort_err", {24'd0, err_g}, 32'd0);
        chk("abort_idx", {24'd0, idx_g}, 32'd0);
        chk("abort_done", {31'd0, done_g}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      start_g = (repulse && (k == 3)) ? 1'b1 : 1'b0;
      tick();
    end
    start_g = 1'b0;
    chk("g_end_busy", {31'd0, busy_g}, 32'd0);
    chk("g_end_done", {31'd0, done_g}, 32'd1);
    chk("g_end_pass", {31'd0, pass_g}, 32'd1);
    chk("g_end_err", {24'd0, err_g}, 32'd0);
    chk("g_end_pat", pat_g, 32'h0);
  endtask

  initial begin
    logic [31:0] s;
    int budget;
    exp_pat[0] = 32'h0000_0000;
    exp_pat[1] = 32'hFFFF_FFFF;
    exp_pat[2] = 32'hAAAA_AAAA;
    exp_pat[3] = 32'h0000_FFFF;
    exp_pat[4] = 32'hCCCC_CCCC;
    s = 32'h1;
    for (int i = 5; i < 21; i++) begin
      s = ref_step(s);
      exp_pat[i] = s;
    end

    // reset state
    #12;
    chk("rst_pat", pat_g, 32'h0);
    chk("rst_busy", {31'd0, busy_g}, 32'd0);
    chk("rst_done", {31'd0, done_g}, 32'd0);
    chk("rst_pass", {31'd0, pass_g}, 32'd0);
    chk("rst_err", {24'd0, err_g}, 32'd0);
    chk("rst_idx", {24'd0, idx_g}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    chk("idle_pat", pat_g, 32'h0);

    // golden run, first random pattern is one step from seed 1
    run_gold(1'b0, -1);
    chk("g_first_rand", exp_pat[5], 32'h8020_0003);
    chk("g_second_rand", exp_pat[6], 32'hC030_0002);
    tick();
    chk("g_done_hold", {31'd0, done_g}, 32'd1);

    // restart from DONE with start re-pulsed mid-run
    run_gold(1'b1, -1);

    // reset mid-run at pat_idx 7, then a clean rerun
    run_gold(1'b0, 7);
    chk("post_rst_done", {31'd0, done_g}, 32'd0);
    run_gold(1'b0, -1);

    // y[0] stuck-at-0, directed only
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    chk("s_pat0", pat_s, 32'h0000_0000);
    chk("s_err0", {24'd0, err_s}, 32'd0);
    tick();
    chk("s_pat1", pat_s, 32'hFFFF_FFFF);
    chk("s_err1", {24'd0, err_s}, 32'd1);
    tick();
    chk("s_err2", {24'd0, err_s}, 32'd1);
    tick();
    chk("s_err3", {24'd0, err_s}, 32'd2);
    tick();
    chk("s_pat4", pat_s, 32'hCCCC_CCCC);
    chk("s_err4", {24'd0, err_s}, 32'd2);
    chk("s_busy4", {31'd0, busy_s}, 32'd1);
    tick();
    chk("s_done", {31'd0, done_s}, 32'd1);
    chk("s_busy", {31'd0, busy_s}, 32'd0);
    chk("s_pass", {31'd0, pass_s}, 32'd0);
    chk("s_err", {24'd0, err_s}, 32'd3);
`ifdef INV32_BIST_FAILLOG_EN
    chk("s_fail_valid", {31'd0, fv_s}, 32'd1);
    chk("s_fail_idx", {24'd0, fi_s}, 32'd0);
    chk("s_fail_pat", fp_s, 32'h0000_0000);
    chk("s_fail_resp", fr_s, 32'hFFFF_FFFE);
`endif

    // all-zero responder, 2-bit saturating counter
    start_t = 1'b1;
    tick();
    start_t = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t_idx4", {24'd0, idx_t}, 32'd4);
    chk("t_err4", {30'd0, err_t}, 32'd3);
    budget = 0;
    while (!done_t && budget < 40) begin
      tick();
      budget++;
    end
    chk("t_done", {31'd0, done_t}, 32'd1);
    chk("t_len", budget, 32'd17);
    chk("t_err", {30'd0, err_t}, 32'd3);
    chk("t_pass", {31'd0, pass_t}, 32'd0);

    // zero seed falls back to seed 1
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("z_idx5", {24'd0, idx_z}, 32'd5);
    chk("z_pat5", pat_z, 32'h8020_0003);
    budget = 0;
    while (!done_z && budget < 40) begin
      tick();
      budget++;
    end
    chk("z_done", {31'd0, done_z}, 32'd1);
    chk("z_pass", {31'd0, pass_z}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
